// File: rtl/sram_resp_pkg.sv
// sram_resp_pkg: shared FSM state, request kinds and default read latency for the SRAM responder
package sram_resp_pkg;
    localparam int READ_LAT_DEF = 2;
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_COMMIT, WR_HOLD} state_e;
    typedef enum logic [1:0] {REQ_IDLE, REQ_READ, REQ_WRITE} req_e;
endpackage

// File: rtl/sram_resp_array.sv
// sram_resp_array: word storage with per-byte write enables and a registered, lane-masked read port
module sram_resp_array #(
    parameter int DEPTH_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [1:0]         wbe_i,
    input  logic [DEPTH_W-1:0] waddr_i,
    input  logic [15:0]        wdata_i,
    input  logic               re_i,
    input  logic [1:0]         rbe_i,
    input  logic [DEPTH_W-1:0] raddr_i,
    output logic [15:0]        rdata_o
);
    logic [15:0] mem [2**DEPTH_W];
    logic [15:0] rdata_q;

    // byte-lane write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (we_i && wbe_i[1]) mem[waddr_i][15:8] <= wdata_i[15:8];
        if (we_i && wbe_i[0]) mem[waddr_i][7:0] <= wdata_i[7:0];
    end

    // read register holds zero whenever the bus is not being driven
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !re_i) rdata_q <= '0;
        else rdata_q <= {rbe_i[1] ? mem[raddr_i][15:8] : 8'h00, rbe_i[0] ? mem[raddr_i][7:0] : 8'h00};
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sram_responder.sv
// sram_responder: SRAM pin-protocol target with wait-state reads and one commit per WE pulse; SRAM_RESP_PROTO_CHK_EN adds the Err checker
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int DEPTH_W  = 16,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Data_oe,
    output logic        Rd_valid
`ifdef SRAM_RESP_PROTO_CHK_EN
    ,output logic       Err
`endif
);
    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    state_e             state_q, state_d;
    req_e               req;
    logic [2:0]         cnt_q, cnt_d;
    logic [DEPTH_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d, addr_in;
    logic [15:0]        wdata_q, wdata_d;
    logic [1:0]         wbe_q, wbe_d;
    logic               oe_q, vld_q;

    assign addr_in = ADDR[DEPTH_W-1:0];
    assign req = (!CE && !WE) ? REQ_WRITE : (!CE && !OE) ? REQ_READ : REQ_IDLE;

    // next state; the write is captured on its first sampled cycle so a long WE pulse commits that value only
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wbe_d   = wbe_q;
        case (state_q)
            IDLE: begin
                if (req == REQ_READ) begin
                    state_d = RD_WAIT;
                    cnt_d   = LAT_M1;
                    raddr_d = addr_in;
                end else if (req == REQ_WRITE) state_d = WR_COMMIT;
            end
            RD_WAIT: begin
                if (req != REQ_READ) state_d = (req == REQ_WRITE) ? WR_COMMIT : IDLE;
                else if (addr_in != raddr_q) begin
                    cnt_d   = LAT_M1;
                    raddr_d = addr_in;
                end else if (cnt_q == 3'd0) state_d = RD_DRIVE;
                else cnt_d = cnt_q - 3'd1;
            end
            RD_DRIVE: begin
                if (req != REQ_READ) state_d = (req == REQ_WRITE) ? WR_COMMIT : IDLE;
                else if (addr_in != raddr_q) begin
                    state_d = RD_WAIT;
                    cnt_d   = LAT_M1;
                    raddr_d = addr_in;
                end
            end
            WR_COMMIT: state_d = WR_HOLD;
            WR_HOLD:   state_d = (req == REQ_WRITE) ? WR_HOLD : IDLE;
            default:   state_d = IDLE;
        endcase
        if (state_q != WR_COMMIT && state_d == WR_COMMIT) begin
            waddr_d = addr_in;
            wdata_d = Data_in;
            wbe_d   = {!UB, !LB};
        end
    end

    // control state with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oe_q    <= state_d == RD_DRIVE;
            vld_q   <= state_d == RD_DRIVE && state_q != RD_DRIVE;
        end
    end

    // address and write-capture registers need no reset
    always_ff @(posedge Clk) begin
        raddr_q <= raddr_d;
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
        wbe_q   <= wbe_d;
    end

    sram_resp_array #(.DEPTH_W(DEPTH_W)) u_array (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .we_i   (Reset && state_q == WR_COMMIT),
        .wbe_i  (wbe_q),
        .waddr_i(waddr_q),
        .wdata_i(wdata_q),
        .re_i   (state_d == RD_DRIVE),
        .rbe_i  ({!UB, !LB}),
        .raddr_i(raddr_q),
        .rdata_o(Data_out)
    );

    assign Data_oe  = oe_q;
    assign Rd_valid = vld_q;

`ifdef SRAM_RESP_PROTO_CHK_EN
    logic err_q;
    // sticky flag for bus contention or a write with both lanes disabled
    always_ff @(posedge Clk) begin
        if (!Reset) err_q <= 1'b0;
        else if ((!CE && !OE && !WE) || (req == REQ_WRITE && UB && LB)) err_q <= 1'b1;
    end
    assign Err = err_q;
`endif
endmodule
